// File: rtl/bresenham_line_stepper_pkg.sv
// Shared types and constants for the Bresenham line stepper.
package bresenham_line_stepper_pkg;

    localparam int unsigned WIDTH = 10;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] YSTEP_POS = 10'h001;
    localparam logic [WIDTH-1:0] YSTEP_NEG = 10'h3FF;

endpackage : bresenham_line_stepper_pkg

// File: rtl/bresenham_line_stepper_if.sv
// Parameter-in and pixel-out handshakes of the line stepper.
interface bresenham_line_stepper_if #(
    parameter int unsigned WIDTH = bresenham_line_stepper_pkg::WIDTH
);
    logic             param_valid;
    logic             param_ready;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y0;
    logic             steep;
    logic [WIDTH-1:0] deltax;
    logic [WIDTH-1:0] deltay;
    logic [WIDTH-1:0] ystep;
    logic             pix_valid;
    logic             pix_ready;
    logic [WIDTH-1:0] pix_x;
    logic [WIDTH-1:0] pix_y;
    logic             line_done;

    modport slave (
        input  param_valid, x0, x1, y0, steep, deltax, deltay, ystep, pix_ready,
        output param_ready, pix_valid, pix_x, pix_y, line_done
    );

    modport master (
        output param_valid, x0, x1, y0, steep, deltax, deltay, ystep, pix_ready,
        input  param_ready, pix_valid, pix_x, pix_y, line_done
    );
endinterface : bresenham_line_stepper_if

// File: rtl/bresenham_line_stepper_err_step.sv
// One Bresenham error update: next err and next minor-axis coordinate.
module bresenham_err_step #(
    parameter int unsigned WIDTH = bresenham_line_stepper_pkg::WIDTH
) (
    input  logic [WIDTH:0]   err_i,
    input  logic [WIDTH-1:0] dx_i,
    input  logic [WIDTH-1:0] dy_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] ys_i,
    output logic [WIDTH:0]   err_o,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH:0] err_sub;

    // Two's complement on WIDTH+1 bits; the MSB is the sign of e'.
    always_comb begin
        err_sub = err_i - {1'b0, dy_i};
        err_o   = err_sub;
        y_o     = y_i;
        if (err_sub[WIDTH]) begin
            err_o = err_sub + {1'b0, dx_i};
            y_o   = y_i + ys_i;
        end
    end
endmodule : bresenham_err_step

// File: rtl/generic_reg.sv
// Enabled register with synchronous active-high reset.
module generic_reg #(
    parameter int unsigned W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule : generic_reg

// File: rtl/bresenham_line_stepper.sv
// Walks the major axis of one line per parameter set and emits screen-space pixels.
module bresenham_line_stepper
    import bresenham_line_stepper_pkg::*;
#(
    parameter int unsigned WIDTH = bresenham_line_stepper_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    bresenham_line_stepper_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   err_q, err_d;
    logic             done_q, done_d;

    logic             stp_q;
    logic [WIDTH-1:0] dx_q, dy_q, ys_q, xend_q;
    logic [WIDTH:0]   err_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             accept_c;

    assign accept_c = (state_q == IDLE) && bus.param_valid;

    generic_reg #(.W(1))     u_stp  (.clk(clk), .rst(rst), .en(accept_c), .d(bus.steep),  .q(stp_q));
    generic_reg #(.W(WIDTH)) u_dx   (.clk(clk), .rst(rst), .en(accept_c), .d(bus.deltax), .q(dx_q));
    generic_reg #(.W(WIDTH)) u_dy   (.clk(clk), .rst(rst), .en(accept_c), .d(bus.deltay), .q(dy_q));
    generic_reg #(.W(WIDTH)) u_ys   (.clk(clk), .rst(rst), .en(accept_c), .d(bus.ystep),  .q(ys_q));
    generic_reg #(.W(WIDTH)) u_xend (.clk(clk), .rst(rst), .en(accept_c), .d(bus.x1),     .q(xend_q));

    bresenham_err_step #(.WIDTH(WIDTH)) u_err_step (
        .err_i (err_q),
        .dx_i  (dx_q),
        .dy_i  (dy_q),
        .y_i   (y_q),
        .ys_i  (ys_q),
        .err_o (err_nxt),
        .y_o   (y_nxt)
    );

    // Next-state: load on accept, step on pixel transfer, finish at xend.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.param_valid) begin
                    x_d     = bus.x0;
                    y_d     = bus.y0;
                    err_d   = {1'b0, bus.deltax >> 1};
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (bus.pix_ready) begin
                    if (x_q == xend_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        x_d   = x_q + WIDTH'(1);
                        y_d   = y_nxt;
                        err_d = err_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Undo the steep swap from registered state only.
    assign bus.param_ready = (state_q == IDLE);
    assign bus.pix_valid   = (state_q == DRAW);
    assign bus.pix_x       = stp_q ? y_q : x_q;
    assign bus.pix_y       = stp_q ? x_q : y_q;
    assign bus.line_done   = done_q;

endmodule : bresenham_line_stepper
